updown_counter_hexdisp: RTL



---
 rtl/updown_counter_hexdisp.sv | 107 ++++++++++
 1 files changed

// File: rtl/updown_counter_hexdisp.sv
// Up/down counter with clamped synchronous load, programmable wrap modulus, terminal-count pulse
// and a registered bank of active-low 7-segment digits. Define UPDOWN_COUNTER_BLANK_EN for leading-zero blanking.
module updown_counter_hexdisp #(
  parameter int                  DIGITS    = 4,
  parameter logic [4*DIGITS-1:0] MAX_COUNT = '1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  up_down,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic [7*DIGITS-1:0]   hex
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0]          count_q, count_d;
  logic                  tc_q, tc_d;
  logic [7*DIGITS-1:0]   hex_q;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0011000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Whole-bank decode; also supplies the reset pattern as disp('0).
  function automatic logic [7*DIGITS-1:0] disp(input logic [W-1:0] v);
    logic [7*DIGITS-1:0] r;
`ifdef UPDOWN_COUNTER_BLANK_EN
    logic lead;
    lead = 1'b1;
`endif
    r = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      r[7*i +: 7] = seg7(v[4*i +: 4]);
`ifdef UPDOWN_COUNTER_BLANK_EN
      // A digit blanks only while it and every higher nibble are zero; digit 0 always shows.
      lead = lead & (v[4*i +: 4] == 4'h0);
      if (lead && (i != 0)) r[7*i +: 7] = 7'b1111111;
`endif
    end
    return r;
  endfunction

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (load) begin
      count_d = (load_value > MAX_COUNT) ? MAX_COUNT : load_value;
    end else if (enable) begin
      if (up_down) begin
        if (count_q == MAX_COUNT) begin
          count_d = '0;
          tc_d    = 1'b1;
        end else begin
          count_d = count_q + W'(1);
        end
      end else begin
        if (count_q == '0) begin
          count_d = MAX_COUNT;
          tc_d    = 1'b1;
        end else begin
          count_d = count_q - W'(1);
        end
      end
    end
  end

  // The display register decodes the current count, so it trails count by one edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      hex_q   <= disp('0);
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      hex_q   <= disp(count_q);
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign hex   = hex_q;

endmodule
